// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: state encoding shared by the round-robin mux arbiter
package rr_mux_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux_generic_1bit.sv
// mux_generic_1bit: n-to-1 single-bit multiplexer
module mux_generic_1bit #(
    parameter int n = 4
) (
    input  logic [n-1:0]         w,
    input  logic [$clog2(n)-1:0] sel,
    output logic                 f
);
    assign f = w[sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter sequencing the select of a shared 1-bit mux
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         w,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] sel,
    output logic                 valid,
    output logic                 f
);
    localparam int SW = $clog2(N);
    localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [SW-1:0]   sel_q, sel_d, last_q, last_d, base, idx, cand;
    logic [HW-1:0]   hold_q, hold_d;
    logic            valid_q, valid_d, cand_found, hold_sat, release_w, mux_f;
    logic [N-1:0]    mask, cand_oh;
    // The owner's own bit is masked out, so in IDLE (grant zero) the full req is searched
    assign mask      = req & ~grant_q;
    assign base      = state_q == GRANT ? sel_q : last_q;
    assign hold_sat  = hold_q == HW'(HOLD_MAX - 1);
    assign release_w = state_q == GRANT && (!req[sel_q] || (hold_sat && |mask));
    assign cand_oh   = {{(N-1){1'b0}}, 1'b1} << cand;
    // Descending scan so the nearest index after base is the one that sticks
    always_comb begin
        cand_found = 1'b0;
        cand = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = SW'((int'(base) + k) % N);
            if (mask[idx]) begin
                cand_found = 1'b1;
                cand = idx;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        last_d  = last_q;
        hold_d  = hold_sat ? hold_q : hold_q + 1'b1;
        if (state_q == IDLE) begin
            hold_d = '0;
            if (cand_found) begin
                state_d = GRANT;
                grant_d = cand_oh;
                sel_d   = cand;
                valid_d = 1'b1;
            end
        end else if (release_w) begin
            last_d  = sel_q;
            hold_d  = '0;
            state_d = cand_found ? GRANT : IDLE;
            grant_d = cand_found ? cand_oh : '0;
            sel_d   = cand_found ? cand : sel_q;
            valid_d = cand_found;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            last_q  <= SW'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end
    mux_generic_1bit #(.n(N)) u_mux (
        .w  (w),
        .sel(sel_q),
        .f  (mux_f)
    );
    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign f     = mux_f & valid_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed literal checks plus randomized run against a behavioural model
module tb_rr_mux_arbiter;
    localparam int N = 4;
    localparam int HOLD_MAX = 4;
    localparam int SW = $clog2(N);
    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, w, grant;
    logic [SW-1:0] sel;
    logic          valid, f;
    int            n_cmp = 0, n_bad = 0;
    bit            chk = 1'b0;
    int            m_owner = -1, m_last = N - 1, m_sel = 0, m_held = 0;
    rr_mux_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset(reset), .req(req), .w(w),
        .grant(grant), .sel(sel), .valid(valid), .f(f)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    function automatic int find(input logic [N-1:0] r, input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction
    // Model: owner index (-1 = none), pointer, and count of cycles the owner has held
    always @(posedge clk) begin
        int o, l, s, h, c;
        o = m_owner; l = m_last; s = m_sel; h = m_held;
        if (reset) begin
            o = -1; l = N - 1; s = 0; h = 0;
        end else if (o < 0) begin
            c = find(req, l, -1);
            if (c >= 0) begin o = c; s = c; h = 1; end
        end else if (!req[o] || (h >= HOLD_MAX && find(req, o, o) >= 0)) begin
            l = o;
            c = find(req, o, o);
            if (c >= 0) begin o = c; s = c; h = 1; end
            else o = -1;
        end else h++;
        m_owner <= o; m_last <= l; m_sel <= s; m_held <= h;
    end
    always @(negedge clk) begin
        if (chk) begin
            check("model_grant", int'(grant), m_owner >= 0 ? (1 << m_owner) : 0);
            check("model_sel", int'(sel), m_sel);
            check("model_valid", int'(valid), m_owner >= 0 ? 1 : 0);
            check("model_f", int'(f), m_owner >= 0 ? int'(w[m_owner]) : 0);
        end
    end
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset = 1'b1; req = 4'b1111; w = 4'b1010;
        edge_step();
        chk = 1'b1;
        edge_step();
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_sel", int'(sel), 0);
        check("rst_f", int'(f), 0);
        check("model_rst_owner", m_owner, -1);
        reset = 1'b0;
        edge_step();
        check("first_grant", int'(grant), 1);
        check("first_sel", int'(sel), 0);
        check("first_f", int'(f), 0);
        req = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            edge_step();
            check("solo_grant", int'(grant), 2);
            check("solo_sel", int'(sel), 1);
            check("solo_f", int'(f), 1);
        end
        reset = 1'b1; req = 4'b1111;
        edge_step();
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            edge_step();
            check("rot_grant", int'(grant), 1 << ((c / 4) % 4));
            check("rot_f", int'(f), ((c / 4) % 2));
        end
        check("model_rot_owner", m_owner, 2);
        reset = 1'b1;
        edge_step();
        check("midrst_grant", int'(grant), 0);
        check("midrst_valid", int'(valid), 0);
        reset = 1'b0;
        edge_step();
        check("postrst_grant", int'(grant), 1);
        req = 4'b0010;
        edge_step();
        check("drop_grant1", int'(grant), 2);
        req = 4'b1010;
        edge_step();
        check("drop_hold", int'(grant), 2);
        req = 4'b1000;
        edge_step();
        check("drop_grant3", int'(grant), 8);
        check("drop_sel", int'(sel), 3);
        check("drop_f", int'(f), 1);
        check("drop_valid", int'(valid), 1);
        req = 4'b0000;
        edge_step();
        check("idle_grant", int'(grant), 0);
        check("idle_valid", int'(valid), 0);
        check("idle_sel", int'(sel), 3);
        req = 4'b1001;
        edge_step();
        check("wrap_grant", int'(grant), 1);
        check("wrap_sel", int'(sel), 0);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(3) == 0) req = N'($urandom);
            w = N'($urandom);
            reset = $urandom_range(63) == 0;
            edge_step();
        end
        reset = 1'b0;
        @(negedge clk);
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
